// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Cleans a raw, asynchronous pushbutton on the 50 MHz quartz clock. A
//   change is accepted only after DEBOUNCE_CYCLES consecutive stable samples.
//   The block produces a debounced level and one-cycle press/release strobes.
//   An optional auto-repeat strobe fires while the button is held. An 8-bit
//   event counter is kept for LED debug.
//
// Ports
//   qzt_clk        in   50 MHz clock; all logic on the rising edge
//   reset          in   asynchronous, active-high reset
//   btn_in         in   raw button, active-high, asynchronous to qzt_clk
//   level          out  debounced state (1 = pressed)
//   press_pulse    out  one-cycle strobe on an accepted press
//   release_pulse  out  one-cycle strobe on an accepted release
//   repeat_pulse   out  one-cycle auto-repeat strobe (0 when REPEAT_EN=0)
//   press_count    out  count of press_pulse + repeat_pulse events, wraps
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 30
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // db_cnt holds the number of stable samples already seen in a wait
    // state. The sample being evaluated completes the run when db_cnt
    // equals DEBOUNCE_CYCLES-1. The wait is entered holding one sample, so
    // a change is accepted on edge DEBOUNCE_CYCLES+2 after btn_in settles.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;   // first repeat already fired
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic [7:0]       count_q, count_d;
    logic [CNT_W-1:0] rep_nxt;

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            s1_q        <= btn_in;
            s2_q        <= s1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        rep_nxt     = rep_cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d     = PRESSED;
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
                    end else begin
                        state_d  = PRESS_WAIT;
                        db_cnt_d = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_armed_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else begin
                        state_d  = RELEASE_WAIT;
                        db_cnt_d = CNT_ONE;
                    end
                end else if (REPEAT_EN != 0) begin
                    // The first strobe waits REPEAT_DELAY cycles. After that
                    // the counter restarts and compares against REPEAT_PERIOD.
                    if (rep_nxt == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
                        repeat_d    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_nxt;
                    end
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes the repeat schedule where
                // it left off, because rep_cnt is not touched here.
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        count_d = count_q + {7'd0, (press_d | repeat_d)};
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//   Directed bench for button_debouncer (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3). Every expected strobe is queued with its cycle number
//   when the stimulus that causes it is driven. Each cycle, the observed
//   strobes are compared with the head of the queue. A second instance with
//   repeat disabled shares the stimulus.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int D = 4;
    localparam logic [2:0] K_PRESS = 3'b100;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_REP   = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        int         at_cyc;
    } ev_t;

    logic       qzt_clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       level, press_pulse, release_pulse, repeat_pulse;
    logic [7:0] press_count;
    logic       nr_level, nr_press, nr_release, nr_repeat;
    logic [7:0] nr_count;

    ev_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    int  base, p;

    always #5 qzt_clk = ~qzt_clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut (
        .qzt_clk(qzt_clk), .reset(reset), .btn_in(btn_in),
        .level(level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
        .press_count(press_count)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut_nr (
        .qzt_clk(qzt_clk), .reset(reset), .btn_in(btn_in),
        .level(nr_level), .press_pulse(nr_press),
        .release_pulse(nr_release), .repeat_pulse(nr_repeat),
        .press_count(nr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input int at);
        ev_t e;
        e.kind   = kind;
        e.at_cyc = at;
        sb.push_back(e);
    endtask

    // One clock: count the edge, then compare the strobes on the falling edge.
    task automatic step();
        logic [2:0] got, exp;
        ev_t e;
        @(posedge qzt_clk);
        cyc++;
        @(negedge qzt_clk);
        got = {press_pulse, release_pulse, repeat_pulse};
        exp = 3'b000;
        if (sb.size() != 0 && sb[0].at_cyc <= cyc) begin
            e   = sb.pop_front();
            exp = e.kind;
        end
        chk("strobes", {29'd0, got}, {29'd0, exp});
        chk("norep_repeat", {31'd0, nr_repeat}, 32'd0);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   {31'd0, level}, 32'd0);
        chk({tag, "_press"},   {31'd0, press_pulse}, 32'd0);
        chk({tag, "_release"}, {31'd0, release_pulse}, 32'd0);
        chk({tag, "_repeat"},  {31'd0, repeat_pulse}, 32'd0);
        chk({tag, "_count"},   {24'd0, press_count}, 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        btn_in = 1'b0;
        // Reset must clear the outputs before any clock edge arrives.
        #1 reset = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge qzt_clk);
        reset = 1'b0;

        // Clean press: accepted on edge 6 after btn_in rises.
        base = cyc; btn_in = 1'b1; push(K_PRESS, base + D + 2);
        run_to(base + D + 1);
        chk("t1_level_before", {31'd0, level}, 32'd0);
        step();
        chk("t1_level", {31'd0, level}, 32'd1);
        step();
        chk("t1_count", {24'd0, press_count}, 32'd1);

        // Release after the clean press.
        base = cyc; btn_in = 1'b0; push(K_REL, base + D + 2);
        run_to(base + D + 1);
        chk("t3_level_before", {31'd0, level}, 32'd1);
        step();
        chk("t3_level", {31'd0, level}, 32'd0);
        chk("t3_count", {24'd0, press_count}, 32'd1);
        repeat (3) step();

        // Bounce 1,0,1,0 every 2 cycles, then hold high: exactly one press.
        for (int i = 0; i < 4; i++) begin
            btn_in = ~i[0];
            step(); step();
        end
        base = cyc; btn_in = 1'b1; push(K_PRESS, base + D + 2);
        run_to(base + D + 2);
        chk("t2_level", {31'd0, level}, 32'd1);
        chk("t2_count", {24'd0, press_count}, 32'd2);

        // Two-cycle low glitch while pressed: level holds, no release.
        step();
        btn_in = 1'b0;
        step(); chk("t4_level_g0", {31'd0, level}, 32'd1);
        step(); chk("t4_level_g1", {31'd0, level}, 32'd1);
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t4_level_hold", {31'd0, level}, 32'd1);
        end
        base = cyc; btn_in = 1'b0; push(K_REL, base + D + 2);
        run_to(base + D + 2);
        chk("t4_level_rel", {31'd0, level}, 32'd0);
        chk("t4_count", {24'd0, press_count}, 32'd2);
        repeat (3) step();

        // Reset while pressed: outputs drop at once, and no release follows.
        base = cyc; btn_in = 1'b1; push(K_PRESS, base + D + 2);
        run_to(base + D + 3);
        chk("t6_count_pre", {24'd0, press_count}, 32'd3);
        reset = 1'b1;
        #1 chk_all_zero("t6_reset");
        chk("t6_nr_level", {31'd0, nr_level}, 32'd0);
        repeat (3) step();
        reset = 1'b0;

        // btn_in still high: new press, then auto-repeat at +10, +13, ...
        base = cyc; p = base + D + 2;
        push(K_PRESS, p);
        for (int k = 0; k < 255; k++) push(K_REP, p + 10 + 3 * k);
        run_to(p);
        chk("t6_count_post", {24'd0, press_count}, 32'd1);
        run_to(p + 30);
        chk("t5_count_30", {24'd0, press_count}, 32'd8);
        chk("t5_nr_count", {24'd0, nr_count}, 32'd1);
        run_to(p + 10 + 3 * 253);
        chk("t5_count_255", {24'd0, press_count}, 32'd255);
        run_to(p + 10 + 3 * 254);
        chk("t5_count_wrap", {24'd0, press_count}, 32'd0);

        base = cyc; btn_in = 1'b0; push(K_REL, base + D + 2);
        run_to(base + D + 4);
        chk("end_level", {31'd0, level}, 32'd0);
        chk("end_count", {24'd0, press_count}, 32'd0);
        chk("end_nr_level", {31'd0, nr_level}, 32'd0);
        chk("end_queue_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
